imem_rom: RTL and testbench
===========================

Name: imem_rom

Overview:
- 256 x 8 instruction memory for the 8-bit core; holds the program fetched by the PC.
- Default program is loaded on reset.
- Read is combinational, addressed by the PC value `ad`.
- A synchronous write port allows run-time program patching by the loader/debug path.

Parameters:
- AW, 8, address width; DEPTH = 2**AW words.
- DW, 8, data/instruction word width.

Ports:
- clk  input  1  system clock; all writes sample on the rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- ad  input  AW  fetch address.
- out  output  DW  instruction word at `ad`.
- we  input  1  write enable; sampled on rising clk.
- wad  input  AW  write address.
- wdata  input  DW  write data.

Behaviour:
- Storage: DEPTH words of DW bits.
- Read path: `out = mem[ad]`, purely combinational, zero-cycle latency.
  - `out` follows any change of `ad` within the same delta/settle time.
  - Every address 0..255 is valid; no out-of-range case and no wrap logic needed.
- Default program contents, restored on reset:
  - 0: 8'h10, 1: 8'h21, 2: 8'h32, 3: 8'h43, 4: 8'h54, 5: 8'h65, 6: 8'h76, 7: 8'h87, 8: 8'h98.
  - Addresses 9..255: 8'h00.
- Reset:
  - `rst_n` low asynchronously forces every location to its default value, independent of clk.
  - While `rst_n` is low, writes are ignored.
  - Since `out` is combinational, it shows the default word for `ad` immediately on reset assertion.
- Write:
  - On rising clk with `rst_n` high and `we` = 1: `mem[wad] <= wdata`.
  - `we` = 0: no change.
- Read-during-write, same address: before the edge `out` shows old data; after the edge it shows `wdata` (write-first is not required combinationally).
- Reset asserted in the same cycle as a write: reset wins; the location holds its default.
- No X propagation: `out` is never X after the first reset assertion.

Optional Feature:
- Macro: IMEM_OUT_REG_EN.
- Defined:
  - `out` is registered: `out <= mem[ad]` on rising clk, giving 1-cycle read latency.
  - `out` resets asynchronously to 8'h00 while `rst_n` is low.
  - Same-address write then read returns the new data on the cycle after the write edge.
- Undefined: combinational read exactly as in Behaviour (default build).

Test Plan:
- Reset, then sweep `ad` = 0..8 with 10 ns per step -> `out` = 10,21,32,43,54,65,76,87,98 (hex), each valid within its step.
- `ad` = 9, 128, 255 after reset -> `out` = 8'h00.
- Write `we`=1, `wad`=8'h05, `wdata`=8'hA5 on one edge, then `ad`=5 -> `out` = 8'hA5; `ad`=4 still reads 8'h54.
- Write 8'h3C to address 2, then pulse `rst_n` low mid-cycle (asynchronously) -> address 2 immediately reads 8'h32 again.
- Hold `rst_n` low with `we`=1, `wad`=0, `wdata`=8'hFF across edges, then release -> `ad`=0 reads 8'h10.
- With IMEM_OUT_REG_EN: after reset `out`=8'h00; set `ad`=3 -> `out`=8'h43 only after the next rising clk.

Source files
------------

// File: rtl/imem_rom.sv
// 256x8 instruction memory: default program restored on async reset, synchronous patch port.
// Optional build macro IMEM_OUT_REG_EN registers the read port (1-cycle latency).
module imem_rom #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ad,
    output logic [DW-1:0] out,
    input  logic          we,
    input  logic [AW-1:0] wad,
    input  logic [DW-1:0] wdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // Boot program image; everything past the listed words is zero.
    function automatic logic [DW-1:0] default_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        case (a)
            AW'(0): w = DW'(8'h10);
            AW'(1): w = DW'(8'h21);
            AW'(2): w = DW'(8'h32);
            AW'(3): w = DW'(8'h43);
            AW'(4): w = DW'(8'h54);
            AW'(5): w = DW'(8'h65);
            AW'(6): w = DW'(8'h76);
            AW'(7): w = DW'(8'h87);
            AW'(8): w = DW'(8'h98);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Reset reloads the whole image and masks any concurrent write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word(AW'(i));
            end
        end else if (we) begin
            mem[wad] <= wdata;
        end
    end

`ifdef IMEM_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= mem[ad];
        end
    end
`else
    assign out = mem[ad];
`endif

endmodule

// File: tb/tb_imem_rom.sv
// Randomized self-checking bench for imem_rom against an array model of the program memory.
module tb_imem_rom;

    logic       clk;
    logic       rst_n;
    logic [7:0] ad;
    logic [7:0] out;
    logic       we;
    logic [7:0] wad;
    logic [7:0] wdata;

    logic [7:0] model [256];
    int unsigned errors;
    int unsigned checks;

    imem_rom #(.AW(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ad    (ad),
        .out   (out),
        .we    (we),
        .wad   (wad),
        .wdata (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Program image: word i holds nibbles {i+1, i} for i < 9, else zero.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            model[i] = (i < 9) ? 8'((i + 1) * 16 + i) : 8'h00;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wad = a; wdata = d;
        @(posedge clk);
        model[a] = d;
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a);
        @(negedge clk);
        ad = a;
`ifdef IMEM_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
        check(tag, out, model[a]);
    endtask

    initial begin
        logic [7:0] exp_post;
        errors = 0;
        checks = 0;
        rst_n = 1'b0; we = 1'b0; wad = '0; wdata = '0; ad = 8'd3;
        model_reset();
        #12;
`ifdef IMEM_OUT_REG_EN
        check("reset_out", out, 8'h00);
`else
        check("reset_out", out, 8'h43);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Default program sweep and zero region.
        for (int i = 0; i < 9; i++) rd($sformatf("default_%0d", i), 8'(i));
        rd("zero_9", 8'd9);
        rd("zero_128", 8'd128);
        rd("zero_255", 8'd255);

        // Patch one word, neighbour untouched.
        wr(8'h05, 8'hA5);
        rd("patch_5", 8'd5);
        rd("neigh_4", 8'd4);

        // Async reset mid-cycle restores the default immediately.
        wr(8'h02, 8'h3C);
        rd("patch_2", 8'd2);
        @(negedge clk);
        ad = 8'd2;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
`ifdef IMEM_OUT_REG_EN
        check("async_rst_out", out, 8'h00);
`else
        check("async_rst_2", out, 8'h32);
`endif
        #1 rst_n = 1'b1;
        rd("after_rst_2", 8'd2);

        // Writes held off while in reset.
        @(negedge clk);
        rst_n = 1'b0; we = 1'b1; wad = 8'h00; wdata = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1;
        rd("rst_blocks_wr", 8'd0);

        // Random traffic with occasional mid-cycle async resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we    = 1'($urandom_range(0, 1));
            wad   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            wdata = 8'($urandom);
            ad    = ($urandom_range(0, 2) == 0) ? wad : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
            end
`ifndef IMEM_OUT_REG_EN
            #1 check("rnd_pre", out, model[ad]);
`endif
            exp_post = model[ad];
            @(posedge clk);
            if (we) model[wad] = wdata;
`ifndef IMEM_OUT_REG_EN
            exp_post = model[ad];
`endif
            #1 check("rnd_post", out, exp_post);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
